hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch/exception redirect,
// instruction-fetch miss stall and a multicycle mul/div stall FSM.
module hazard_ctrl #(
    parameter int MD_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        md_start,
    input  logic        imem_ready,
    input  logic        ext_flush,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        flush_id,
    output logic        bubble_ex,
    output logic        bubble_mem,
    output logic        redirect_en,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1
    } state_t;

    localparam logic [5:0] MD_RELOAD = 6'(MD_LATENCY - 2);

    state_t      state_q, state_d;
    logic [5:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        load_use;

    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_id    = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        redirect_en = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        // Outputs are forced low while reset is held, independent of inputs.
        if (!rst) begin
            if (ext_flush) begin
                redirect_en = 1'b1;
                flush_id    = 1'b1;
                bubble_ex   = 1'b1;
                bubble_mem  = 1'b1;
                state_d     = RUN;
                md_cnt_d    = 6'd0;
            end else if (state_q == MD_WAIT) begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                bubble_mem = 1'b1;
                md_busy    = 1'b1;
                if (md_cnt_q == 6'd0) begin
                    md_done = 1'b1;
                    state_d = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 6'd1;
                end
            end else if (ex_branch_taken) begin
                redirect_en = 1'b1;
                flush_id    = 1'b1;
                bubble_ex   = 1'b1;
                state_d     = RUN;
            end else if (md_start) begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                bubble_mem = 1'b1;
                md_cnt_d   = MD_RELOAD;
                state_d    = MD_WAIT;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
                state_d   = RUN;
            end else if (!imem_ready) begin
                stall_if = 1'b1;
                flush_id = 1'b1;
                state_d  = RUN;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_if && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            md_cnt_q       <= 6'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_memread;
    logic        ex_branch_taken, md_start, imem_ready, ext_flush;
    logic        stall_if, stall_id, stall_ex, flush_id, bubble_ex, bubble_mem;
    logic        redirect_en, md_busy, md_done;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .md_start(md_start),
        .imem_ready(imem_ready), .ext_flush(ext_flush),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .bubble_ex(bubble_ex), .bubble_mem(bubble_mem),
        .redirect_en(redirect_en), .md_busy(md_busy), .md_done(md_done),
        .stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       memread;
        logic [4:0] rd;
        logic       br;
        logic       mds;
        logic       imr;
        logic       xf;
    } stim_t;

    // Output order: stall_if stall_id stall_ex flush_id bubble_ex bubble_mem redirect_en md_busy md_done
    typedef struct packed {
        logic [8:0]  outs;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          done_drv = 1'b0;

    // Model state: number of mul/div wait cycles still to come, and the stall tally.
    int          md_rem = 0;
    logic [31:0] m_cnt = 32'd0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.imr = 1'b1;
        return s;
    endfunction

    function automatic logic [8:0] model_outs(input stim_t s, input int rem);
        logic lu;
        lu = s.memread && (s.rd != 0) &&
             ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
        if (s.rst)         return 9'b000000000;
        if (s.xf)          return 9'b000111100;
        if (rem > 0)       return {6'b111001, 1'b0, 1'b1, (rem == 1)};
        if (s.br)          return 9'b000110100;
        if (s.mds)         return 9'b111001000;
        if (lu)            return 9'b110010000;
        if (!s.imr)        return 9'b100100000;
        return 9'b000000000;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst             = s.rst;
        id_rs           = s.rs;
        id_rt           = s.rt;
        id_uses_rs      = s.urs;
        id_uses_rt      = s.urt;
        ex_memread      = s.memread;
        ex_rd           = s.rd;
        ex_branch_taken = s.br;
        md_start        = s.mds;
        imem_ready      = s.imr;
        ext_flush       = s.xf;
        if (s.rst) begin
            md_rem = 0;
            m_cnt  = 32'd0;
        end
        e.outs = model_outs(s, md_rem);
        e.cnt  = m_cnt;
        sb_q.push_back(e);
        // Advance the model to what the next rising edge produces.
        if (!s.rst) begin
            if (e.outs[8] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (s.xf)              md_rem = 0;
            else if (md_rem > 0)   md_rem = md_rem - 1;
            else if (s.mds && !s.br) md_rem = LAT - 1;
        end
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) drive(idle());
    endtask

    // Monitor: every cycle the DUT presents a combinational response.
    initial begin : monitor
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {stall_if, stall_id, stall_ex, flush_id, bubble_ex,
                       bubble_mem, redirect_en, md_busy, md_done};
                checks++;
                if (act !== e.outs) begin
                    failures++;
                    $display("FAIL outs t=%0t actual=%b required=%b", $time, act, e.outs);
                end
                checks++;
                if (stall_cycles !== e.cnt) begin
                    failures++;
                    $display("FAIL stall_cycles t=%0t actual=%h required=%h", $time, stall_cycles, e.cnt);
                end
                checks++;
                if (flush_id && stall_id) begin
                    failures++;
                    $display("FAIL flush_stall_excl t=%0t actual=11 required=not both", $time);
                end
            end
        end
    end

    initial begin : driver
        stim_t s;
        rst = 1'b1;
        {id_rs, id_rt, ex_rd} = '0;
        {id_uses_rs, id_uses_rt, ex_memread} = '0;
        {ex_branch_taken, md_start, ext_flush} = '0;
        imem_ready = 1'b1;

        // Reset holds everything low even with every request active.
        s = '1; drive(s); drive(s);
        s = idle(); s.rst = 1'b1; drive(s);
        run_idle(2);

        // Load-use on rs, then the same with r0 as destination.
        s = idle(); s.memread = 1; s.rd = 5'd5; s.rs = 5'd5; s.urs = 1; drive(s);
        run_idle(1);
        s.rd = 5'd0; s.rs = 5'd0; drive(s);
        s = idle(); s.memread = 1; s.rd = 5'd9; s.rt = 5'd9; s.urt = 1; drive(s);
        run_idle(1);

        // Mul/div of LAT cycles, then resume.
        s = idle(); s.mds = 1; drive(s);
        run_idle(LAT + 1);

        // Taken branch during a fetch miss.
        s = idle(); s.br = 1; s.imr = 0; drive(s);
        s = idle(); s.imr = 0; drive(s);

        // md_start beats load-use; ext_flush aborts the wait.
        s = idle(); s.mds = 1; s.memread = 1; s.rd = 5'd3; s.rs = 5'd3; s.urs = 1; drive(s);
        s = idle(); s.br = 1; s.imr = 0; drive(s);
        s = idle(); s.xf = 1; drive(s);
        run_idle(LAT);

        // Reset pulse in the middle of a wait.
        s = idle(); s.mds = 1; drive(s);
        drive(idle());
        s = idle(); s.rst = 1; drive(s);
        run_idle(LAT);

        // Saturation: preload the tally just below the maximum.
        @(posedge clk); #1;
        force dut.stall_cycles_q = 32'hFFFF_FFFC;
        m_cnt = 32'hFFFF_FFFC;
        drive(idle());
        @(posedge clk); #1;
        release dut.stall_cycles_q;
        s = idle(); s.imr = 0;
        for (int i = 0; i < 8; i++) drive(s);
        @(negedge clk); #3;
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL saturate actual=%h required=ffffffff", stall_cycles);
        end
        s = idle(); s.rst = 1; drive(s);
        run_idle(1);

        // Random traffic with small register numbers to make hazards frequent.
        for (int i = 0; i < 3000; i++) begin
            s.rst     = ($urandom_range(0, 199) == 0);
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.rd      = 5'($urandom_range(0, 3));
            s.urs     = 1'($urandom_range(0, 1));
            s.urt     = 1'($urandom_range(0, 1));
            s.memread = 1'($urandom_range(0, 1));
            s.br      = ($urandom_range(0, 7) == 0);
            s.mds     = ($urandom_range(0, 7) == 0);
            s.imr     = ($urandom_range(0, 3) != 0);
            s.xf      = ($urandom_range(0, 15) == 0);
            drive(s);
        end
        run_idle(2);
        done_drv = 1'b1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!done_drv && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        repeat (2) @(posedge clk);
        checks++;
        if (!done_drv || sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0 (done=%0d)", sb_q.size(), done_drv);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
